// File: rtl/pmem_scheduler_if.sv
// rtl/pmem_scheduler_if.sv - icache/dcache/physical-memory handshake bundle
//
// Ports carried by the bundle:
//   i_pmem_read, i_pmem_address   icache line-fill request and line address
//   i_pmem_resp                   icache transaction complete
//   d_pmem_read, d_pmem_write     dcache line-fill / write-back request
//   d_pmem_address                dcache line address
//   d_pmem_resp                   dcache transaction complete
//   pmem_read, pmem_write         physical memory strobes
//   pmem_address                  physical memory address
//   pmem_resp                     physical memory completion
// The scheduler takes the slave modport; caches and memory take master.

interface pmem_scheduler_if #(
  parameter int AW = 16
);
  logic          i_pmem_read;
  logic [AW-1:0] i_pmem_address;
  logic          i_pmem_resp;
  logic          d_pmem_read;
  logic          d_pmem_write;
  logic [AW-1:0] d_pmem_address;
  logic          d_pmem_resp;
  logic          pmem_read;
  logic          pmem_write;
  logic [AW-1:0] pmem_address;
  logic          pmem_resp;

  modport slave (
    input  i_pmem_read, i_pmem_address,
    input  d_pmem_read, d_pmem_write, d_pmem_address,
    input  pmem_resp,
    output i_pmem_resp, d_pmem_resp,
    output pmem_read, pmem_write, pmem_address
  );

  modport master (
    output i_pmem_read, i_pmem_address,
    output d_pmem_read, d_pmem_write, d_pmem_address,
    output pmem_resp,
    input  i_pmem_resp, d_pmem_resp,
    input  pmem_read, pmem_write, pmem_address
  );
endinterface

// File: rtl/pmem_scheduler.sv
// rtl/pmem_scheduler.sv - arbitrates one physical memory port between icache and dcache
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   bus        pmem_scheduler_if.slave: cache requests/responses and memory strobes
//   d_owner    1 = dcache owns the port (steers pmem wdata/rdata)
//   ld_regs    pipeline latch enable, 1 = no memory transaction in flight
//   proto_err  sticky: dcache read and write were requested together
//
// The dcache normally wins contention; after STARVE_MAX consecutive contended
// dcache grants the icache is forced ahead once. Every transaction ends with a
// single DONE cycle in which nothing is granted, giving the finished requester
// time to drop its request.

module pmem_scheduler #(
  parameter int STARVE_MAX = 4,
  parameter int AW         = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  pmem_scheduler_if.slave bus,
  output logic            d_owner,
  output logic            ld_regs,
  output logic            proto_err
);

  localparam int            SW         = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    I_BUSY = 2'd1,
    D_BUSY = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic          rd_q, rd_d;
  logic          wr_q, wr_d;
  logic          own_q, own_d;
  logic          err_q, err_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [SW-1:0] starve_q, starve_d;
  logic          i_req, d_req, i_wins;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      own_q    <= 1'b0;
      err_q    <= 1'b0;
      addr_q   <= '0;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      own_q    <= own_d;
      err_q    <= err_d;
      addr_q   <= addr_d;
      starve_q <= starve_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    rd_d            = rd_q;
    wr_d            = wr_q;
    own_d           = own_q;
    err_d           = err_q;
    addr_d          = addr_q;
    starve_d        = starve_q;
    bus.i_pmem_resp = 1'b0;
    bus.d_pmem_resp = 1'b0;
    // Pipeline latches stay enabled while reset is held, whatever the inputs.
    ld_regs         = !rst_n;
    i_req           = bus.i_pmem_read;
    d_req           = bus.d_pmem_read | bus.d_pmem_write;
    i_wins          = i_req && (!d_req || (starve_q == STARVE_LIM));

    case (state_q)
      IDLE: begin
        if (!i_req && !d_req) begin
          ld_regs = 1'b1;
        end
        // Grant: latch address and operation; strobes rise next cycle.
        if (i_wins) begin
          state_d  = I_BUSY;
          addr_d   = bus.i_pmem_address;
          rd_d     = 1'b1;
          wr_d     = 1'b0;
          own_d    = 1'b0;
          starve_d = '0;
        end else if (d_req) begin
          state_d = D_BUSY;
          addr_d  = bus.d_pmem_address;
          // Read and write together is a protocol error; the write wins.
          wr_d    = bus.d_pmem_write;
          rd_d    = bus.d_pmem_read & ~bus.d_pmem_write;
          own_d   = 1'b1;
          if (bus.d_pmem_read && bus.d_pmem_write) begin
            err_d = 1'b1;
          end
          if (i_req && (starve_q < STARVE_LIM)) begin
            starve_d = starve_q + 1'b1;
          end
        end
      end
      I_BUSY: begin
        bus.i_pmem_resp = bus.pmem_resp;
        if (bus.pmem_resp) begin
          state_d = DONE;
          rd_d    = 1'b0;
          wr_d    = 1'b0;
        end
      end
      D_BUSY: begin
        bus.d_pmem_resp = bus.pmem_resp;
        if (bus.pmem_resp) begin
          state_d = DONE;
          rd_d    = 1'b0;
          wr_d    = 1'b0;
        end
      end
      DONE: begin
        ld_regs = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.pmem_read    = rd_q;
  assign bus.pmem_write   = wr_q;
  assign bus.pmem_address = addr_q;
  assign d_owner          = own_q;
  assign proto_err        = err_q;

endmodule

// File: tb/tb_pmem_scheduler.sv
// tb/tb_pmem_scheduler.sv - self-checking bench for pmem_scheduler

module tb_pmem_scheduler;

  localparam int AW         = 16;
  localparam int STARVE_MAX = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic d_owner, ld_regs, proto_err;

  pmem_scheduler_if #(.AW(AW)) bus ();

  pmem_scheduler #(.STARVE_MAX(STARVE_MAX), .AW(AW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .d_owner   (d_owner),
    .ld_regs   (ld_regs),
    .proto_err (proto_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Memory: answers a strobe in its resp_lat-th cycle, or on demand via force_resp.
  int resp_lat   = 1;
  int resp_cnt   = 0;
  bit force_resp = 1'b0;
  initial bus.pmem_resp = 1'b0;
  always @(posedge clk) begin
    #2;
    if (bus.pmem_read === 1'b1 || bus.pmem_write === 1'b1) resp_cnt = resp_cnt + 1;
    else resp_cnt = 0;
    bus.pmem_resp = force_resp || (resp_cnt != 0 && resp_cnt == resp_lat);
  end

  // Transaction-level model: one transaction at a time, each followed by one quiet cycle.
  bit            m_busy, m_done, m_is_d, m_wr, m_owner, m_err;
  logic [AW-1:0] m_addr;
  int            m_starve;

  always @(posedge clk or negedge rst_n) begin : model
    bit ireq, dreq;
    if (!rst_n) begin
      m_busy = 0; m_done = 0; m_is_d = 0; m_wr = 0; m_owner = 0; m_err = 0;
      m_addr = '0; m_starve = 0;
    end else if (m_done) begin
      m_done = 0;
    end else if (m_busy) begin
      if (bus.pmem_resp) begin
        m_busy = 0;
        m_done = 1;
      end
    end else begin
      ireq = bus.i_pmem_read;
      dreq = bus.d_pmem_read || bus.d_pmem_write;
      if (ireq && (!dreq || m_starve >= STARVE_MAX)) begin
        m_busy = 1; m_is_d = 0; m_wr = 0; m_owner = 0;
        m_addr = bus.i_pmem_address; m_starve = 0;
      end else if (dreq) begin
        m_busy = 1; m_is_d = 1; m_owner = 1;
        m_wr   = bus.d_pmem_write;
        m_addr = bus.d_pmem_address;
        if (bus.d_pmem_read && bus.d_pmem_write) m_err = 1;
        if (ireq) m_starve = (m_starve + 1 > STARVE_MAX) ? STARVE_MAX : m_starve + 1;
      end
    end
  end

  bit chk_en = 1'b0;
  always @(negedge clk) begin
    if (chk_en) begin
      chk("pmem_read",    bus.pmem_read,    m_busy && !m_wr);
      chk("pmem_write",   bus.pmem_write,   m_busy && m_wr);
      chk("pmem_address", bus.pmem_address, m_addr);
      chk("i_pmem_resp",  bus.i_pmem_resp,  m_busy && !m_is_d && bus.pmem_resp);
      chk("d_pmem_resp",  bus.d_pmem_resp,  m_busy && m_is_d && bus.pmem_resp);
      chk("d_owner",      d_owner,          m_owner);
      chk("ld_regs",      ld_regs,          !rst_n || m_done ||
          (!m_busy && !(bus.i_pmem_read || bus.d_pmem_read || bus.d_pmem_write)));
      chk("proto_err",    proto_err,        m_err);
    end
  end

  // Observation: grant order and strobe-cycle totals.
  string glog = "";
  int    rd_tot = 0, wr_tot = 0;
  bit    prev_stb = 1'b0;
  always @(negedge clk) begin : monitor
    string s;
    if ((bus.pmem_read === 1'b1 || bus.pmem_write === 1'b1) && !prev_stb) begin
      s = d_owner ? "D" : "I";
      glog = {glog, s};
    end
    prev_stb = (bus.pmem_read === 1'b1 || bus.pmem_write === 1'b1);
    if (bus.pmem_read === 1'b1)  rd_tot++;
    if (bus.pmem_write === 1'b1) wr_tot++;
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_resp(input bit want_d, input string nm);
    bit seen = 1'b0;
    for (int k = 0; k < 60 && !seen; k++) begin
      @(negedge clk);
      seen = want_d ? bus.d_pmem_resp : bus.i_pmem_resp;
    end
    if (!seen) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: no response within 60 cycles", nm);
    end
  endtask

  task automatic chk_order(input string nm, input int from, input string exp);
    chk({nm, "_len"}, glog.len(), from + exp.len());
    for (int i = 0; i < exp.len(); i++) begin
      if (from + i < glog.len()) chk(nm, glog[from+i], exp[i]);
    end
  endtask

  initial begin
    int  n, p, g0, w0, r0;
    bit  seen;

    bus.i_pmem_read = 0; bus.i_pmem_address = '0;
    bus.d_pmem_read = 0; bus.d_pmem_write = 0; bus.d_pmem_address = '0;

    // Reset values.
    cyc(3);
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst_pmem_read", bus.pmem_read, 0);
    chk("rst_pmem_write", bus.pmem_write, 0);
    chk("rst_addr", bus.pmem_address, 0);
    chk("rst_d_owner", d_owner, 0);
    chk("rst_ld_regs", ld_regs, 1);
    chk("rst_proto_err", proto_err, 0);
    cyc(1);
    rst_n = 1'b1;
    cyc(2);

    // Icache-only read at 0x1230, 3-cycle memory; address input moves mid-flight.
    resp_lat = 3; n = 0; p = 0; seen = 0;
    bus.i_pmem_address = 16'h1230;
    bus.i_pmem_read    = 1;
    for (int k = 0; k < 30 && !seen; k++) begin
      @(negedge clk);
      if (bus.pmem_read && bus.pmem_address == 16'h1230) n++;
      if (bus.i_pmem_resp) begin p++; seen = 1; end
      if (!seen && k == 1) begin
        @(posedge clk); #1;
        bus.i_pmem_address = 16'hBEEF;
      end
    end
    cyc(1);
    bus.i_pmem_read = 0;
    cyc(2);
    chk("t1_strobe_cycles_at_1230", n, 3);
    chk("t1_resp_pulses", p, 1);

    // Simultaneous icache/dcache reads: dcache first, then icache.
    resp_lat = 2;
    g0 = glog.len();
    bus.i_pmem_address = 16'h0100; bus.i_pmem_read = 1;
    bus.d_pmem_address = 16'h0200; bus.d_pmem_read = 1;
    wait_resp(1, "t2_dcache");
    cyc(1);
    bus.d_pmem_read = 0;
    wait_resp(0, "t2_icache");
    cyc(1);
    bus.i_pmem_read = 0;
    cyc(2);
    chk_order("t2_order", g0, "DI");

    // Both held continuously: starvation guard forces every fifth grant to icache.
    resp_lat = 1;
    g0 = glog.len();
    bus.i_pmem_address = 16'h0400; bus.i_pmem_read = 1;
    bus.d_pmem_address = 16'h0300; bus.d_pmem_read = 1;
    for (int k = 0; k < 200 && glog.len() < g0 + 10; k++) @(posedge clk);
    #1;
    bus.i_pmem_read = 0; bus.d_pmem_read = 0;
    cyc(5);
    chk_order("t3_order", g0, "DDDDIDDDDI");

    // Read and write together: write wins, proto_err sticks.
    resp_lat = 2;
    w0 = wr_tot; r0 = rd_tot;
    bus.d_pmem_address = 16'h0ABC;
    bus.d_pmem_read = 1; bus.d_pmem_write = 1;
    wait_resp(1, "t4_dcache");
    cyc(1);
    bus.d_pmem_read = 0; bus.d_pmem_write = 0;
    cyc(2);
    @(negedge clk);
    chk("t4_write_cycles", wr_tot - w0, 2);
    chk("t4_read_cycles", rd_tot - r0, 0);
    chk("t4_proto_err", proto_err, 1);
    cyc(1);

    // Stray memory response while idle is ignored.
    g0 = glog.len();
    force_resp = 1;
    @(negedge clk);
    chk("t5_i_resp", bus.i_pmem_resp, 0);
    chk("t5_d_resp", bus.d_pmem_resp, 0);
    chk("t5_ld_regs", ld_regs, 1);
    cyc(1);
    force_resp = 0;
    cyc(2);
    chk("t5_no_grant", glog.len(), g0);

    // Reset mid D_BUSY drops strobes at once; nothing is retried.
    resp_lat = 20;
    bus.d_pmem_address = 16'h0F00; bus.d_pmem_write = 1;
    cyc(3);
    chk("t6_pre_write", bus.pmem_write, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_write", bus.pmem_write, 0);
    chk("t6_read", bus.pmem_read, 0);
    chk("t6_addr", bus.pmem_address, 0);
    chk("t6_d_owner", d_owner, 0);
    chk("t6_proto_err", proto_err, 0);
    chk("t6_ld_regs", ld_regs, 1);
    chk("t6_d_resp", bus.d_pmem_resp, 0);
    cyc(1);
    bus.d_pmem_write = 0;
    cyc(2);
    rst_n = 1'b1;
    g0 = glog.len(); w0 = wr_tot;
    cyc(5);
    chk("t6_no_retry_grant", glog.len(), g0);
    chk("t6_no_retry_write", wr_tot - w0, 0);

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pmem_scheduler.md
PMEM_SCHEDULER -- requirements
Module: pmem_scheduler

Interface
REQ-001 Parameter: STARVE_MAX, default 4, meaning the number of consecutive contended dcache grants before icache is forced ahead.
REQ-002 Parameter: AW, default 16, meaning the physical address width.
REQ-003 Port: clk  in  1  single system clock; all state changes on the rising edge.
REQ-004 Port: rst_n  in  1  reset, asynchronous and active-low.
REQ-005 Port: i_pmem_read  in  1  icache line-fill request.
REQ-006 Port: i_pmem_address  in  AW  icache line address.
REQ-007 Port: i_pmem_resp  out  1  icache transaction complete.
REQ-008 Port: d_pmem_read  in  1  dcache line-fill request.
REQ-009 Port: d_pmem_write  in  1  dcache write-back request.
REQ-010 Port: d_pmem_address  in  AW  dcache line address.
REQ-011 Port: d_pmem_resp  out  1  dcache transaction complete.
REQ-012 Port: pmem_read  out  1  physical memory read strobe.
REQ-013 Port: pmem_write  out  1  physical memory write strobe.
REQ-014 Port: pmem_address  out  AW  physical memory address.
REQ-015 Port: pmem_resp  in  1  physical memory completion.
REQ-016 Port: d_owner  out  1  1 = dcache owns the port; selects the pmem_wdata/rdata steering.
REQ-017 Port: ld_regs  out  1  pipeline latch enable; 1 = no memory transaction in flight.
REQ-018 Port: proto_err  out  1  sticky flag: dcache read and write were requested together.

Function
REQ-019 The FSM SHALL have exactly four states: IDLE, I_BUSY, D_BUSY and DONE.
REQ-020 In IDLE with only the icache requesting, the next state SHALL be I_BUSY.
REQ-021 In IDLE with only the dcache requesting (read or write), the next state SHALL be D_BUSY.
REQ-022 In IDLE with both requesting and starve_cnt < STARVE_MAX, the dcache SHALL be granted.
REQ-023 In IDLE with both requesting and starve_cnt == STARVE_MAX, the icache SHALL be granted.
REQ-024 At grant, the requester's address and operation SHALL be latched; pmem_address and the strobes SHALL be driven from these latches, never from the live inputs.
REQ-025 pmem_read/pmem_write SHALL be registered: asserted the cycle after grant and held until the cycle pmem_resp is sampled high in a BUSY state.
REQ-026 pmem_resp SHALL be routed combinationally: to i_pmem_resp in I_BUSY, to d_pmem_resp in D_BUSY, and to neither in other states.
REQ-027 pmem_resp sampled in IDLE or DONE SHALL be ignored.
REQ-028 On pmem_resp in a BUSY state, the next state SHALL be DONE, with strobes deasserted.
REQ-029 DONE SHALL last exactly one cycle, then go to IDLE; no grant is made in DONE, so the completing requester can drop its request.
REQ-030 starve_cnt (width clog2(STARVE_MAX+1)) SHALL increment, saturating at STARVE_MAX, on each dcache grant made while the icache is also requesting.
REQ-031 starve_cnt SHALL clear on any icache grant and SHALL be unchanged on an uncontended dcache grant.
REQ-032 When d_pmem_read and d_pmem_write are both high at grant, the transaction SHALL be a write and proto_err SHALL set; it clears only on reset.
REQ-033 d_owner SHALL be 1 in D_BUSY, and SHALL hold its last value in IDLE and DONE.
REQ-034 ld_regs SHALL be 1 in DONE, 1 in IDLE when no request is pending, and 0 otherwise.
REQ-035 Latency from request (in IDLE) to strobe SHALL be 1 cycle; back-to-back grants SHALL be spaced by at least one DONE cycle.

Reset
REQ-036 While rst_n = 0, the following SHALL hold: state=IDLE, pmem_read=0, pmem_write=0, pmem_address=0, d_owner=0, starve_cnt=0, proto_err=0, i_pmem_resp=0, d_pmem_resp=0, ld_regs=1.
REQ-037 Reset asserted mid-transaction SHALL drop the strobes immediately (asynchronously); the aborted transaction SHALL NOT be retried.

Verification
REQ-038 Icache-only read at 0x1230, pmem_resp after 3 cycles -> pmem_read=1 with address 0x1230 for 3 cycles, one i_pmem_resp pulse, then DONE, then IDLE; ld_regs=0 throughout the transaction.
REQ-039 Simultaneous i and d reads -> dcache served first; icache is granted the cycle after the dcache DONE; starve_cnt goes 1 then 0.
REQ-040 Icache and dcache both held high continuously with STARVE_MAX=4 -> grant order D,D,D,D,I,D,D,D,D,I.
REQ-041 d_pmem_read and d_pmem_write both high -> pmem_write=1, pmem_read=0, proto_err=1, and proto_err stays 1 after the transaction.
REQ-042 pmem_resp pulsed in IDLE -> no response output and no state change; rst_n dropped during D_BUSY -> pmem_write=0 in the same cycle, and all REQ-036 values hold.
REQ-043 Requester address changes mid-transaction -> pmem_address stays at the granted value.
